// File: rtl/lap_timer_core_if.sv
// Command and status bundle for the lap timer core.
// master drives the command pulses and reads the timer outputs;
// slave is the timer core itself.
interface lap_timer_core_if;
   logic        start_stop;
   logic        lap;
   logic        clear;
   logic [19:0] cur_time;
   logic [19:0] last_lap;
   logic [19:0] best_lap;
   logic        best_valid;
   logic [7:0]  lap_cnt;
   logic        lap_valid;
   logic        new_best;
   logic        running;
   logic        ovf;

   modport master (
      output start_stop, lap, clear,
      input  cur_time, last_lap, best_lap, best_valid, lap_cnt,
             lap_valid, new_best, running, ovf
   );

   modport slave (
      input  start_stop, lap, clear,
      output cur_time, last_lap, best_lap, best_valid, lap_cnt,
             lap_valid, new_best, running, ovf
   );
endinterface

// File: rtl/lap_timer_core.sv
// Lap timer: a prescaled elapsed-time counter with lap capture, best-lap
// tracking and a saturating lap count, controlled by one-cycle command pulses.
module lap_timer_core #(
   parameter int unsigned CLK_DIV  = 500000,
   parameter int unsigned MAX_TIME = 999999
) (
   input  logic             clk,
   input  logic             rst_n,
   lap_timer_core_if.slave  bus
);

   localparam logic [23:0] PRESC_LAST = 24'(CLK_DIV - 1);
   localparam logic [19:0] TIME_LAST  = 20'(MAX_TIME);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] presc_q, presc_d;
   logic [19:0] cur_time_q, cur_time_d;
   logic [19:0] lap_start_q, lap_start_d;
   logic [19:0] last_lap_q, last_lap_d;
   logic [19:0] best_lap_q, best_lap_d;
   logic        best_valid_q, best_valid_d;
   logic [7:0]  lap_cnt_q, lap_cnt_d;
   logic        lap_valid_q, lap_valid_d;
   logic        new_best_q, new_best_d;
   logic        ovf_q, ovf_d;

   logic        tick;
   logic        go_idle;
   logic [19:0] lap_len;

   // Lap length uses the registered (pre-tick) time; saturation keeps it non-negative.
   assign lap_len = cur_time_q - lap_start_q;

   // Next-state and datapath: command decoding, prescaler, time counter and lap bookkeeping.
   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      cur_time_d   = cur_time_q;
      lap_start_d  = lap_start_q;
      last_lap_d   = last_lap_q;
      best_lap_d   = best_lap_q;
      best_valid_d = best_valid_q;
      lap_cnt_d    = lap_cnt_q;
      lap_valid_d  = 1'b0;
      new_best_d   = 1'b0;
      ovf_d        = ovf_q;
      tick         = 1'b0;
      go_idle      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.clear) begin
               go_idle = 1'b1;
            end else if (bus.start_stop) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               tick    = 1'b1;
            end else begin
               presc_d = presc_q + 24'd1;
            end
            if (tick) begin
               if (cur_time_q == TIME_LAST) begin
                  ovf_d = 1'b1;
               end else begin
                  cur_time_d = cur_time_q + 20'd1;
               end
            end
            if (bus.lap) begin
               last_lap_d  = lap_len;
               lap_start_d = cur_time_q;
               lap_valid_d = 1'b1;
               if (lap_cnt_q != 8'hFF) begin
                  lap_cnt_d = lap_cnt_q + 8'd1;
               end
               if (!best_valid_q || (lap_len <= best_lap_q)) begin
                  best_lap_d   = lap_len;
                  best_valid_d = 1'b1;
                  new_best_d   = 1'b1;
               end
            end
            if (bus.start_stop) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (bus.clear) begin
               state_d = IDLE;
               go_idle = 1'b1;
            end else if (bus.start_stop) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            go_idle = 1'b1;
         end
      endcase

      if (go_idle) begin
         presc_d      = '0;
         cur_time_d   = '0;
         lap_start_d  = '0;
         last_lap_d   = '0;
         best_lap_d   = '0;
         best_valid_d = 1'b0;
         lap_cnt_d    = '0;
         ovf_d        = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         cur_time_q   <= '0;
         lap_start_q  <= '0;
         last_lap_q   <= '0;
         best_lap_q   <= '0;
         best_valid_q <= 1'b0;
         lap_cnt_q    <= '0;
         lap_valid_q  <= 1'b0;
         new_best_q   <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         cur_time_q   <= cur_time_d;
         lap_start_q  <= lap_start_d;
         last_lap_q   <= last_lap_d;
         best_lap_q   <= best_lap_d;
         best_valid_q <= best_valid_d;
         lap_cnt_q    <= lap_cnt_d;
         lap_valid_q  <= lap_valid_d;
         new_best_q   <= new_best_d;
         ovf_q        <= ovf_d;
      end
   end

   assign bus.cur_time   = cur_time_q;
   assign bus.last_lap   = last_lap_q;
   assign bus.best_lap   = best_lap_q;
   assign bus.best_valid = best_valid_q;
   assign bus.lap_cnt    = lap_cnt_q;
   assign bus.lap_valid  = lap_valid_q;
   assign bus.new_best   = new_best_q;
   assign bus.running    = (state_q == RUN);
   assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_lap_timer_core.sv
// Testbench for lap_timer_core: directed scenarios plus randomized command
// pulses, all checked cycle by cycle against a behavioural model.
module tb_lap_timer_core;

   localparam int CLK_DIV  = 4;
   localparam int MAX_TIME = 20;

   logic clk;
   logic rst_n;
   int   testsRun;
   int   testsFailed;

   lap_timer_core_if bus ();

   lap_timer_core #(
      .CLK_DIV  (CLK_DIV),
      .MAX_TIME (MAX_TIME)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: elapsed time is total RUN cycles since clear divided
   // by CLK_DIV, clamped; laps are kept as a list of durations.
   bit mActive;
   bit mRunning;
   int runCycles;
   int lapStart;
   int lapQ[$];
   bit mLapValid;
   bit mNewBest;

   function automatic int mUnits();
      return runCycles / CLK_DIV;
   endfunction

   function automatic int mCurTime();
      return (mUnits() > MAX_TIME) ? MAX_TIME : mUnits();
   endfunction

   function automatic int mBest();
      int best;
      best = 0;
      foreach (lapQ[i]) begin
         if (i == 0 || lapQ[i] < best) best = lapQ[i];
      end
      return best;
   endfunction

   function automatic int mLastLap();
      return (lapQ.size() == 0) ? 0 : lapQ[lapQ.size() - 1];
   endfunction

   function automatic int mLapCnt();
      return (lapQ.size() > 255) ? 255 : lapQ.size();
   endfunction

   task automatic clearModel();
      runCycles = 0;
      lapStart  = 0;
      lapQ.delete();
   endtask

   task automatic modelStep(input bit ss, input bit lp, input bit clr, input bit rstn);
      int newLap;
      bit isBest;
      mLapValid = 1'b0;
      mNewBest  = 1'b0;
      if (!rstn) begin
         clearModel();
         mActive  = 1'b0;
         mRunning = 1'b0;
      end else if (!mActive) begin
         if (clr) begin
            clearModel();
         end else if (ss) begin
            mActive  = 1'b1;
            mRunning = 1'b1;
         end
      end else if (mRunning) begin
         if (lp) begin
            newLap = mCurTime() - lapStart;
            isBest = (lapQ.size() == 0) || (newLap <= mBest());
            lapQ.push_back(newLap);
            lapStart  = mCurTime();
            mLapValid = 1'b1;
            mNewBest  = isBest;
         end
         if (runCycles < (MAX_TIME + 2) * CLK_DIV) runCycles++;
         if (ss) mRunning = 1'b0;
      end else begin
         if (clr) begin
            clearModel();
            mActive  = 1'b0;
            mRunning = 1'b0;
         end else if (ss) begin
            mRunning = 1'b1;
         end
      end
   endtask

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("cur_time",   32'(bus.cur_time),   32'(mCurTime()));
      checkOutput("last_lap",   32'(bus.last_lap),   32'(mLastLap()));
      checkOutput("best_lap",   32'(bus.best_lap),   32'(mBest()));
      checkOutput("best_valid", 32'(bus.best_valid), 32'(lapQ.size() != 0));
      checkOutput("lap_cnt",    32'(bus.lap_cnt),    32'(mLapCnt()));
      checkOutput("lap_valid",  32'(bus.lap_valid),  32'(mLapValid));
      checkOutput("new_best",   32'(bus.new_best),   32'(mNewBest));
      checkOutput("running",    32'(bus.running),    32'(mRunning));
      checkOutput("ovf",        32'(bus.ovf),        32'(mUnits() > MAX_TIME));
   endtask

   // Drive one cycle of inputs, advance the model on the same edge, check after it.
   task automatic applyStimulus(input bit ss, input bit lp, input bit clr, input bit rstn);
      @(negedge clk);
      bus.start_stop = ss;
      bus.lap        = lp;
      bus.clear      = clr;
      rst_n          = rstn;
      @(posedge clk);
      modelStep(ss, lp, clr, rstn);
      #1;
      checkAll();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic runToTime(input int target);
      int n;
      n = 0;
      while (mCurTime() != target && n < 500) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         n++;
      end
      checkOutput("run_to_time", 32'(bus.cur_time), 32'(target));
   endtask

   initial begin
      testsRun       = 0;
      testsFailed    = 0;
      bus.start_stop = 1'b0;
      bus.lap        = 1'b0;
      bus.clear      = 1'b0;
      rst_n          = 1'b0;
      clearModel();
      mActive   = 1'b0;
      mRunning  = 1'b0;
      mLapValid = 1'b0;
      mNewBest  = 1'b0;

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_cur_time", 32'(bus.cur_time), 32'd0);
      checkOutput("reset_running",  32'(bus.running),  32'd0);

      // Start, then 40 cycles of running
      applyStimulus(1'b1, 1'b0, 0, 1'b1);
      idleCycles(40);
      checkOutput("run40_cur_time", 32'(bus.cur_time), 32'd10);
      checkOutput("run40_running",  32'(bus.running),  32'd1);
      checkOutput("run40_ovf",      32'(bus.ovf),      32'd0);

      // Laps at 5, 12, 15
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      runToTime(5);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("lap1_last", 32'(bus.last_lap), 32'd5);
      checkOutput("lap1_best", 32'(bus.best_lap), 32'd5);
      checkOutput("lap1_nb",   32'(bus.new_best), 32'd1);
      runToTime(12);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("lap2_last", 32'(bus.last_lap), 32'd7);
      checkOutput("lap2_best", 32'(bus.best_lap), 32'd5);
      checkOutput("lap2_nb",   32'(bus.new_best), 32'd0);
      runToTime(15);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("lap3_last", 32'(bus.last_lap), 32'd3);
      checkOutput("lap3_best", 32'(bus.best_lap), 32'd3);
      checkOutput("lap3_nb",   32'(bus.new_best), 32'd1);
      checkOutput("lap3_cnt",  32'(bus.lap_cnt),  32'd3);

      // Lap and pause together, hold, then resume
      runToTime(17);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("lapss_last",    32'(bus.last_lap),  32'd2);
      checkOutput("lapss_valid",   32'(bus.lap_valid), 32'd1);
      checkOutput("lapss_running", 32'(bus.running),   32'd0);
      idleCycles(20);
      checkOutput("pause_frozen",  32'(bus.cur_time),  32'd17);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("pause_lap_ign", 32'(bus.lap_cnt),   32'd4);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("resume_running", 32'(bus.running),  32'd1);

      // Saturation, then a lap at the ceiling
      idleCycles(100);
      checkOutput("sat_cur_time", 32'(bus.cur_time), 32'd20);
      checkOutput("sat_ovf",      32'(bus.ovf),      32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("sat_lap_last", 32'(bus.last_lap), 32'd3);
      checkOutput("sat_lap_cnt",  32'(bus.lap_cnt),  32'd5);

      // Clear ignored in RUN, honoured in PAUSE
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("clr_run_cnt",  32'(bus.lap_cnt), 32'd5);
      checkOutput("clr_run_run",  32'(bus.running), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("pause_ovf_sticky", 32'(bus.ovf), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("clr_pause_time", 32'(bus.cur_time),   32'd0);
      checkOutput("clr_pause_bv",   32'(bus.best_valid), 32'd0);
      checkOutput("clr_pause_cnt",  32'(bus.lap_cnt),    32'd0);
      checkOutput("clr_pause_ovf",  32'(bus.ovf),        32'd0);

      // Clear wins over start_stop in PAUSE
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      idleCycles(6);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("clr_prio_running", 32'(bus.running),  32'd0);
      checkOutput("clr_prio_time",    32'(bus.cur_time), 32'd0);

      // Reset mid-RUN with two laps, then immediate restart
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      runToTime(3);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("prerst_cnt", 32'(bus.lap_cnt), 32'd2);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("rst_cnt",     32'(bus.lap_cnt),  32'd0);
      checkOutput("rst_time",    32'(bus.cur_time), 32'd0);
      checkOutput("rst_running", 32'(bus.running),  32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("post_rst_start", 32'(bus.running), 32'd1);

      // Lap held high: every cycle is a lap, count saturates at 255
      for (int i = 0; i < 260; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("lap_cnt_sat", 32'(bus.lap_cnt), 32'd255);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

      // Randomized command traffic
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(19) == 0,
                       $urandom_range(7) == 0,
                       $urandom_range(14) == 0,
                       $urandom_range(199) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/lap_timer_core.md
LAP_TIMER_CORE -- requirements
Module: lap_timer_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 500000, clock cycles per time unit (one unit = 10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter MAX_TIME, default 999999, saturation value of the time counter in units; must be < 2^20.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start_stop  input  1  one-cycle command pulse: start, pause or resume.
REQ-006 SHALL have port lap  input  1  one-cycle command pulse: close the current lap.
REQ-007 SHALL have port clear  input  1  one-cycle command pulse: return to zero.
REQ-008 SHALL have port cur_time  output  20  elapsed time in units, time_t encoding.
REQ-009 SHALL have port last_lap  output  20  duration of the most recently closed lap.
REQ-010 SHALL have port best_lap  output  20  shortest closed lap since clear.
REQ-011 SHALL have port best_valid  output  1  best_lap holds at least one lap.
REQ-012 SHALL have port lap_cnt  output  8  closed laps since clear.
REQ-013 SHALL have port lap_valid  output  1  one-cycle pulse when last_lap updates.
REQ-014 SHALL have port new_best  output  1  one-cycle pulse when best_lap updates.
REQ-015 SHALL have ports running  output  1  state is RUN; ovf  output  1  cur_time has saturated.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, PAUSE.
REQ-017 SHALL transition IDLE->RUN, RUN->PAUSE and PAUSE->RUN on start_stop.
REQ-018 SHALL transition from PAUSE or IDLE to IDLE on clear, and SHALL ignore clear while in RUN.
REQ-019 SHALL clear cur_time, last_lap, best_lap, best_valid, lap_cnt, ovf, the prescaler and the lap-start register on entry to IDLE.
REQ-020 SHALL count the prescaler 0..CLK_DIV-1 only in RUN, SHALL hold it in PAUSE, and SHALL zero it on entry to IDLE.
REQ-021 SHALL assert an internal tick in the cycle where the prescaler equals CLK_DIV-1, and the prescaler SHALL wrap to 0.
REQ-022 SHALL increment cur_time by 1 on the clock edge of each tick.
REQ-023 SHALL hold cur_time at MAX_TIME and set ovf when a tick occurs at MAX_TIME; ovf SHALL stay sticky until IDLE; cur_time SHALL never wrap.
REQ-024 SHALL act on lap only in RUN: last_lap <= cur_time - lap_start, computed with 20-bit unsigned arithmetic (always non-negative because of saturation).
REQ-025 SHALL load lap_start <= cur_time on the same lap edge.
REQ-026 SHALL use the registered, pre-tick cur_time value for lap arithmetic when lap coincides with a tick.
REQ-027 SHALL increment lap_cnt on each lap, saturating at 255, and SHALL pulse lap_valid in the following cycle.
REQ-028 SHALL evaluate the best-lap rule on each lap: if best_valid=0, or the new lap is <= best_lap, then best_lap <= the new lap, best_valid <= 1, and new_best SHALL pulse with lap_valid. Ties count as a new best.
REQ-029 SHALL ignore lap in IDLE and PAUSE: no output changes.
REQ-030 SHALL process lap first when lap and start_stop coincide in RUN, then enter PAUSE; both effects SHALL be visible in the next cycle.
REQ-031 SHALL give clear priority over start_stop when both arrive in PAUSE; the state SHALL go to IDLE.
REQ-032 SHALL register all outputs, so command effects appear one clock after the pulse edge.
REQ-033 SHALL treat a pulse held high for N cycles as N commands; debouncing is upstream.

Reset
REQ-034 SHALL, while rst_n=0 at a clk edge, enter IDLE and drive all outputs to 0; reset SHALL take priority over every command, including mid-RUN.
REQ-035 SHALL accept commands from the first edge with rst_n=1.

Verification (CLK_DIV=4, MAX_TIME=20)
REQ-036 SHALL cover: start_stop, then 40 cycles -> cur_time=10, running=1, ovf=0.
REQ-037 SHALL cover: laps at cur_time 5, 12, 15 -> last_lap 5, 7, 3; best_lap 5, 5, 3; new_best pulses on laps 1 and 3 only; lap_cnt=3.
REQ-038 SHALL cover: run 100 cycles -> cur_time=20, ovf=1; a lap issued then returns last_lap = 20 - lap_start.
REQ-039 SHALL cover: in RUN, pulse lap and start_stop together -> lap captured, state PAUSE, cur_time frozen for 20 cycles; start_stop then resumes with the prescaler continuing from its held value.
REQ-040 SHALL cover: clear in RUN -> ignored; clear in PAUSE -> all outputs 0, best_valid=0, state IDLE.
REQ-041 SHALL cover: rst_n=0 for one cycle mid-RUN with lap_cnt=2 -> next cycle all outputs 0, state IDLE.
